// File: rtl/score_glyph_render.sv
// Two-digit score overlay: scales two 3x5 glyph bitmaps into a fixed screen box
// and blinks the digits for a while after the score changes.
module score_glyph_render #(
  parameter logic [9:0] X0           = 10'd560,
  parameter logic [9:0] Y0           = 10'd16,
  parameter int         SCALE_LOG2   = 3,
  parameter logic [7:0] BLINK_FRAMES = 8'd48
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [14:0] tens_glyph,
  input  logic [14:0] ones_glyph,
  input  logic        frame_start,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_active,
  output logic        pixel_on,
  output logic        pixel_valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BLINK = 1'b1;

  logic [14:0] tens_sh;
  logic [14:0] ones_sh;
  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [7:0]  blink_cnt;
  logic [7:0]  blink_cnt_next;
  logic        glyph_changed;

  assign glyph_changed = {tens_glyph, ones_glyph} != {tens_sh, ones_sh};

  // Blink bookkeeping only advances on frame boundaries.
  always_comb begin
    state_next     = state;
    blink_cnt_next = blink_cnt;
    if (frame_start) begin
      if (state == IDLE) begin
        if (glyph_changed && (BLINK_FRAMES != 8'd0)) begin
          state_next     = BLINK;
          blink_cnt_next = BLINK_FRAMES;
        end
      end else begin
        if (glyph_changed && (BLINK_FRAMES != 8'd0)) begin
          blink_cnt_next = BLINK_FRAMES;
        end else if (blink_cnt <= 8'd1) begin
          state_next     = IDLE;
          blink_cnt_next = 8'd0;
        end else begin
          blink_cnt_next = blink_cnt - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tens_sh   <= 15'd0;
      ones_sh   <= 15'd0;
      state     <= IDLE;
      blink_cnt <= 8'd0;
    end else begin
      state     <= state_next;
      blink_cnt <= blink_cnt_next;
      if (frame_start) begin
        tens_sh <= tens_glyph;
        ones_sh <= ones_glyph;
      end
    end
  end

  logic [9:0] dx;
  logic [9:0] dy;
  logic [9:0] cx_full;
  logic [9:0] cy_full;
  logic       in_box;

  // The explicit >= tests stop an underflowed dx/dy from aliasing into the box.
  assign dx      = hcount - X0;
  assign dy      = vcount - Y0;
  assign cx_full = dx >> SCALE_LOG2;
  assign cy_full = dy >> SCALE_LOG2;
  assign in_box  = (hcount >= X0) && (vcount >= Y0) &&
                   (cx_full < 10'd7) && (cy_full < 10'd5);

  logic       in_box_reg;
  logic [2:0] cx_reg;
  logic [2:0] cy_reg;
  logic       active_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_box_reg <= 1'b0;
      cx_reg     <= 3'd0;
      cy_reg     <= 3'd0;
      active_reg <= 1'b0;
    end else begin
      in_box_reg <= in_box;
      cx_reg     <= cx_full[2:0];
      cy_reg     <= cy_full[2:0];
      active_reg <= video_active;
    end
  end

  // Flattened 7x5 cell map (index cy*7+cx), padded to 64 so any cx/cy is safe.
  logic [63:0] cell_map;

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_cell
      localparam int CY = gi / 7;
      localparam int CX = gi % 7;
      if (gi >= 35) begin : g_pad
        assign cell_map[gi] = 1'b0;
      end else if (CX < 3) begin : g_tens
        assign cell_map[gi] = tens_sh[3*CY + CX];
      end else if (CX == 3) begin : g_gap
        assign cell_map[gi] = 1'b0;
      end else begin : g_ones
        assign cell_map[gi] = ones_sh[3*CY + CX - 4];
      end
    end
  endgenerate

  logic [5:0] cell_idx;
  logic       cell_bit;
  logic       blank;

  assign cell_idx = 6'(cy_reg) * 6'd7 + 6'(cx_reg);
  assign cell_bit = cell_map[cell_idx];
  assign blank    = (state == BLINK) && blink_cnt[2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixel_on    <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_on    <= active_reg && in_box_reg && cell_bit && !blank;
      pixel_valid <= active_reg;
    end
  end

endmodule

// File: doc/score_glyph_render.md
SCORE_GLYPH_RENDER -- requirements
Module: score_glyph_render

Interface
REQ-001 Parameter X0, default 10'd560: left pixel column of the score box.
REQ-002 Parameter Y0, default 10'd16: top pixel row of the score box.
REQ-003 Parameter SCALE_LOG2, default 3: each glyph cell is 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels; legal range 0..4.
REQ-004 Parameter BLINK_FRAMES, default 8'd48: frames digits blink after a score change; 0 disables blinking.
REQ-005 clk  input  1: sole clock; all state updates on its rising edge.
REQ-006 resetn  input  1: asynchronous, active-low reset.
REQ-007 tens_glyph  input  15: tens-digit bitmap; bits [3r+2:3r] are row r (row 0 top); bit 3r+c is column c (c=0 leftmost).
REQ-008 ones_glyph  input  15: ones-digit bitmap, same packing as tens_glyph.
REQ-009 frame_start  input  1: one-cycle pulse, asserted only during vertical blanking, once per frame.
REQ-010 hcount  input  10: current pixel column.
REQ-011 vcount  input  10: current pixel row.
REQ-012 video_active  input  1: high when (hcount, vcount) is a visible pixel.
REQ-013 pixel_on  output  1: high when the pixel sampled two cycles earlier is a lit score cell.
REQ-014 pixel_valid  output  1: video_active delayed by two cycles.

Function
REQ-015 Glyph inputs are sampled only into shadow registers tens_sh/ones_sh on cycles with frame_start=1; rendering uses only the shadows (no mid-frame tearing).
REQ-016 Box geometry in cells: 7 wide x 5 high; tens digit in cell columns 0-2, blank gap column 3, ones digit in columns 4-6.
REQ-017 dx = hcount-X0, dy = vcount-Y0 (10-bit unsigned); in_box is true when hcount>=X0, vcount>=Y0, dx>>SCALE_LOG2 < 7 and dy>>SCALE_LOG2 < 5.
REQ-018 Stage 1 (registered): in_box, cell column cx = dx>>SCALE_LOG2 (3 bits), cell row cy = dy>>SCALE_LOG2 (3 bits), video_active.
REQ-019 Stage 2 (registered): pixel_on = stage1 video_active AND in_box AND glyph bit AND NOT blank; bit = tens_sh[3cy+cx] for cx 0-2, 0 for cx 3, ones_sh[3cy+cx-4] for cx 4-6.
REQ-020 Latency: exactly 2 clk cycles from hcount/vcount/video_active to pixel_on/pixel_valid; one pixel per cycle, no stalls.
REQ-021 Blink FSM states IDLE and BLINK; 8-bit counter blink_cnt.
REQ-022 IDLE -> BLINK on frame_start when {tens_glyph,ones_glyph} != {tens_sh,ones_sh} and BLINK_FRAMES != 0; blink_cnt loads BLINK_FRAMES.
REQ-023 In BLINK, each frame_start with unchanged glyphs decrements blink_cnt; when decremented to 0, return to IDLE.
REQ-024 In BLINK, a frame_start with changed glyphs reloads blink_cnt with BLINK_FRAMES and stays in BLINK.
REQ-025 blank = (state==BLINK) AND blink_cnt[2]; blank is 0 in IDLE.
REQ-026 Shadow, FSM and blink_cnt updates from frame_start take effect for stage-2 pixels whose stage-1 sample is taken in the cycle after frame_start.
REQ-027 Box partially off-screen or beyond 10-bit range: pixels outside are simply never in_box; no wrap-around lighting at column/row 0.

Reset
REQ-028 While resetn=0: pixel_on=0, pixel_valid=0, all pipeline registers 0, tens_sh=ones_sh=0, state IDLE, blink_cnt=0.
REQ-029 Reset asserted mid-frame or mid-blink clears everything immediately (asynchronously); after release, the first frame_start with nonzero glyphs enters BLINK.
REQ-030 After resetn release, outputs reflect inputs from the third rising edge onward.

Verification
REQ-031 Defaults; glyphs tens=0 (all 0), ones=digit 8 rows {111,101,111,101,111}; frame_start; scan frame -> lit pixels exactly at columns 592-615, rows 16-55, with the 8x8 hole at cell (5,1) and (5,3) dark; tens area dark.
REQ-032 Change ones_glyph mid-frame (no frame_start) -> rendered pixels unchanged until after the next frame_start.
REQ-033 Score change at frame N -> BLINK; blink_cnt=48; digits hidden during frames where blink_cnt[2]=1; IDLE and steady display after 48 frame_starts.
REQ-034 Second change during BLINK when blink_cnt=10 -> blink_cnt reloads to 48, state stays BLINK.
REQ-035 Drive hcount=X0, vcount=Y0, video_active=1 with tens row 0 = 111 in one cycle -> pixel_on=1, pixel_valid=1 exactly 2 cycles later; video_active=0 -> pixel_on=0.
REQ-036 Pulse resetn low mid-frame during BLINK -> pixel_on/pixel_valid drop to 0 without a clock edge; state IDLE, shadows 0.
